// File: rtl/prbs16_checker.sv
// Self-synchronizing receive checker for the 16-bit LFSR source: locks to the
// incoming stream, then flags and counts bit errors and loss-of-sync events.
//
// state  | meaning
// FILL   | loading 16 received bits into the local LFSR
// VERIFY | counting consecutive correct predictions toward lock
// LOCKED | free-running on predictions, monitoring errors per window
module prbs16_checker #(
    parameter int POLY_SEL   = 0,
    parameter int LOCK_CNT   = 32,
    parameter int WIN_LEN    = 256,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [7:0]       relock_cnt_o
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      sreg_q, sreg_d;
    logic [4:0]       fill_cnt_q, fill_cnt_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic [15:0]      win_cnt_q, win_cnt_d;
    logic [15:0]      win_err_q, win_err_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       relock_cnt_q, relock_cnt_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;

    logic             pred;
    logic             mismatch;
    logic [15:0]      shift_rx;
    logic [4:0]       fill_inc;
    logic             fill_done;
    logic [7:0]       match_inc;
    logic             match_done;
    logic [16:0]      win_cnt_inc;
    logic [16:0]      win_err_inc;
    logic             win_end;
    logic             thresh_hit;

    if (POLY_SEL == 0) begin : g_poly0
        assign pred = sreg_q[15] ^ sreg_q[13] ^ sreg_q[12] ^ sreg_q[10];
    end else begin : g_poly1
        assign pred = sreg_q[15] ^ sreg_q[14] ^ sreg_q[12] ^ sreg_q[3];
    end

    assign mismatch    = bit_i ^ pred;
    assign shift_rx    = {sreg_q[14:0], bit_i};
    assign fill_inc    = (fill_cnt_q == 5'd16) ? 5'd16 : fill_cnt_q + 5'd1;
    // an all-zero register is the LFSR lock-up state and can never be accepted
    assign fill_done   = (fill_inc == 5'd16) && (shift_rx != 16'd0);
    assign match_inc   = match_cnt_q + 8'd1;
    assign match_done  = (int'(match_inc) == LOCK_CNT);
    assign win_cnt_inc = {1'b0, win_cnt_q} + 17'd1;
    assign win_err_inc = {1'b0, win_err_q} + {16'd0, mismatch};
    assign win_end     = (int'(win_cnt_inc) == WIN_LEN);
    assign thresh_hit  = (int'(win_err_inc) >= ERR_THRESH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            sreg_q       <= '0;
            fill_cnt_q   <= '0;
            match_cnt_q  <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            bit_cnt_q    <= '0;
            err_cnt_q    <= '0;
            relock_cnt_q <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            fill_cnt_q   <= fill_cnt_d;
            match_cnt_q  <= match_cnt_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            bit_cnt_q    <= bit_cnt_d;
            err_cnt_q    <= err_cnt_d;
            relock_cnt_q <= relock_cnt_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (valid_i) begin
            case (state_q)
                FILL:    if (fill_done) state_d = VERIFY;
                VERIFY: begin
                    if (mismatch)        state_d = FILL;
                    else if (match_done) state_d = LOCKED;
                end
                LOCKED:  if (thresh_hit) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        sreg_d       = sreg_q;
        fill_cnt_d   = fill_cnt_q;
        match_cnt_d  = match_cnt_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        bit_cnt_d    = bit_cnt_q;
        err_cnt_d    = err_cnt_q;
        relock_cnt_d = relock_cnt_q;
        err_pulse_d  = 1'b0;
        if (valid_i) begin
            case (state_q)
                FILL: begin
                    sreg_d     = shift_rx;
                    fill_cnt_d = fill_inc;
                    if (fill_done) match_cnt_d = '0;
                end
                VERIFY: begin
                    sreg_d = shift_rx;
                    if (mismatch) begin
                        fill_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_inc;
                        if (match_done) begin
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    // shifting the prediction keeps one bad bit from corrupting later predictions
                    sreg_d    = {sreg_q[14:0], pred};
                    bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
                    if (mismatch) begin
                        err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
                        err_pulse_d = 1'b1;
                    end
                    if (thresh_hit) begin
                        fill_cnt_d   = '0;
                        relock_cnt_d = (&relock_cnt_q) ? relock_cnt_q : relock_cnt_q + 8'd1;
                    end else if (win_end) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_inc[15:0];
                        win_err_d = win_err_inc[15:0];
                    end
                end
                default: fill_cnt_d = '0;
            endcase
        end
        if (clear_i) begin
            bit_cnt_d    = '0;
            err_cnt_d    = '0;
            relock_cnt_d = '0;
        end
        locked_d = (state_d == LOCKED);
    end

    assign locked_o     = locked_q;
    assign err_pulse_o  = err_pulse_q;
    assign bit_cnt_o    = bit_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign relock_cnt_o = relock_cnt_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: two instances (default taps, and alternate taps with
// short lock/window settings) fed LFSR streams with injected errors, gaps and clears.
module tb_prbs16_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       clr = 1'b0;
    logic       bit0 = 1'b0;
    logic       bit1 = 1'b0;
    logic       locked0, pulse0, locked1, pulse1;
    logic [31:0] bc0, ec0;
    logic [5:0]  bc1, ec1;
    logic [7:0]  rc0, rc1;

    always #5 clk = ~clk;

    prbs16_checker #(.POLY_SEL(0)) dut0 (
        .clk(clk), .rst(rst), .bit_i(bit0), .valid_i(valid), .clear_i(clr),
        .locked_o(locked0), .err_pulse_o(pulse0), .bit_cnt_o(bc0),
        .err_cnt_o(ec0), .relock_cnt_o(rc0)
    );

    prbs16_checker #(.POLY_SEL(1), .LOCK_CNT(5), .WIN_LEN(16), .ERR_THRESH(3), .CNT_W(6)) dut1 (
        .clk(clk), .rst(rst), .bit_i(bit1), .valid_i(valid), .clear_i(clr),
        .locked_o(locked1), .err_pulse_o(pulse1), .bit_cnt_o(bc1),
        .err_cnt_o(ec1), .relock_cnt_o(rc1)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        bit     locked;
        bit     pulse;
        longint bits;
        longint errs;
        longint relock;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int     p_poly [2] = '{0, 1};
    int     p_lock [2] = '{32, 5};
    int     p_win  [2] = '{256, 16};
    int     p_th   [2] = '{8, 3};
    longint p_cmax [2] = '{64'h0000_0000_FFFF_FFFF, 64'd63};

    // reference model: phase 0 = filling, 1 = verifying, 2 = locked
    int     m_phase [2];
    bit     m_hist  [2][16];
    int     m_fill  [2];
    int     m_match [2];
    int     m_win   [2];
    int     m_werr  [2];
    longint m_bits  [2];
    longint m_errs  [2];
    longint m_relock[2];
    bit     m_pulse [2];

    logic [15:0] tx_s [2] = '{16'h0005, 16'h1234};

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // s(k) is the bit shifted in k steps ago
    function automatic bit s_of(input int i, input int k);
        return m_hist[i][15-k];
    endfunction

    function automatic bit model_pred(input int i);
        if (p_poly[i] == 0) return s_of(i, 15) ^ s_of(i, 13) ^ s_of(i, 12) ^ s_of(i, 10);
        return s_of(i, 15) ^ s_of(i, 14) ^ s_of(i, 12) ^ s_of(i, 3);
    endfunction

    task automatic hist_push(input int i, input bit b);
        for (int k = 0; k < 15; k++) m_hist[i][k] = m_hist[i][k+1];
        m_hist[i][15] = b;
    endtask

    task automatic model_step(input int i, input bit v, input bit b, input bit c, input bit r);
        bit p;
        bit nz;
        m_pulse[i] = 1'b0;
        if (r) begin
            m_phase[i] = 0;
            for (int k = 0; k < 16; k++) m_hist[i][k] = 1'b0;
            m_fill[i] = 0; m_match[i] = 0; m_win[i] = 0; m_werr[i] = 0;
            m_bits[i] = 0; m_errs[i] = 0; m_relock[i] = 0;
            return;
        end
        if (v) begin
            p = model_pred(i);
            if (m_phase[i] == 0) begin
                hist_push(i, b);
                if (m_fill[i] < 16) m_fill[i]++;
                nz = 1'b0;
                for (int k = 0; k < 16; k++) nz |= m_hist[i][k];
                if (m_fill[i] == 16 && nz) begin
                    m_phase[i] = 1;
                    m_match[i] = 0;
                end
            end else if (m_phase[i] == 1) begin
                hist_push(i, b);
                if (b == p) begin
                    m_match[i]++;
                    if (m_match[i] == p_lock[i]) begin
                        m_phase[i] = 2; m_win[i] = 0; m_werr[i] = 0;
                    end
                end else begin
                    m_phase[i] = 0; m_fill[i] = 0;
                end
            end else begin
                hist_push(i, p);
                if (m_bits[i] < p_cmax[i]) m_bits[i]++;
                if (b != p) begin
                    if (m_errs[i] < p_cmax[i]) m_errs[i]++;
                    m_pulse[i] = 1'b1;
                    m_werr[i]++;
                end
                m_win[i]++;
                if (m_werr[i] >= p_th[i]) begin
                    m_phase[i] = 0; m_fill[i] = 0;
                    if (m_relock[i] < 255) m_relock[i]++;
                end else if (m_win[i] == p_win[i]) begin
                    m_win[i] = 0; m_werr[i] = 0;
                end
            end
        end
        if (c) begin
            m_bits[i] = 0; m_errs[i] = 0; m_relock[i] = 0;
        end
    endtask

    function automatic bit tx_fb(input logic [15:0] s, input int sel);
        if (sel == 0) return s[15] ^ s[13] ^ s[12] ^ s[10];
        return s[15] ^ s[14] ^ s[12] ^ s[3];
    endfunction

    // one clock of stimulus; zero forces bit_i=0 without advancing the transmitters
    task automatic cyc(input bit v, input bit inv0, input bit inv1, input bit c,
                       input bit r, input bit zero);
        bit   b [2];
        bit   inv [2];
        bit   nb;
        exp_t e;
        inv[0] = inv0;
        inv[1] = inv1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (v && zero) begin
                b[i] = 1'b0;
            end else if (v) begin
                nb = tx_fb(tx_s[i], p_poly[i]);
                tx_s[i] = {tx_s[i][14:0], nb};
                b[i] = nb ^ inv[i];
            end else begin
                b[i] = 1'($urandom);
            end
            model_step(i, v, b[i], c, r);
        end
        bit0 = b[0]; bit1 = b[1]; valid = v; clr = c; rst = r;
        e.locked = (m_phase[0] == 2); e.pulse = m_pulse[0];
        e.bits = m_bits[0]; e.errs = m_errs[0]; e.relock = m_relock[0];
        sb0.push_back(e);
        e.locked = (m_phase[1] == 2); e.pulse = m_pulse[1];
        e.bits = m_bits[1]; e.errs = m_errs[1]; e.relock = m_relock[1];
        sb1.push_back(e);
    endtask

    task automatic clean(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic lock_after_48(input string name);
        for (int n = 1; n <= 48; n++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (n >= 47) begin
                settle();
                chk(name, locked0, (n == 48) ? 1 : 0);
            end
        end
    endtask

    // scoreboard monitor: one expected entry per clock per instance
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                chk("sb0_locked", locked0, e.locked);
                chk("sb0_pulse",  pulse0,  e.pulse);
                chk("sb0_bits",   bc0,     e.bits);
                chk("sb0_errs",   ec0,     e.errs);
                chk("sb0_relock", rc0,     e.relock);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                chk("sb1_locked", locked1, e.locked);
                chk("sb1_pulse",  pulse1,  e.pulse);
                chk("sb1_bits",   bc1,     e.bits);
                chk("sb1_errs",   ec1,     e.errs);
                chk("sb1_relock", rc1,     e.relock);
            end
        end
    end

    initial begin
        int  vcount;
        bit  v;
        repeat (2) do_reset();
        settle();
        chk("rst_locked", locked0, 0);
        chk("rst_pulse",  pulse0,  0);
        chk("rst_bits",   bc0,     0);
        chk("rst_errs",   ec0,     0);
        chk("rst_relock", rc0,     0);

        // clean stream from reset
        lock_after_48("clean_lock_at_48");
        clean(952);
        settle();
        chk("clean_bits",   bc0, 952);
        chk("clean_errs",   ec0, 0);
        chk("clean_relock", rc0, 0);
        chk("poly1_locked", locked1, 1);

        // single inversion
        clean(151);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("single_pulse", pulse0, 1);
        chk("single_errs",  ec0, 1);
        clean(500);
        settle();
        chk("single_errs_after", ec0, 1);
        chk("single_locked",     locked0, 1);

        // 8-bit burst loses lock, then relock
        do_reset();
        clean(68);
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        chk("burst_locked", locked0, 0);
        chk("burst_errs",   ec0, 8);
        chk("burst_relock", rc0, 1);
        lock_after_48("burst_relock_at_48");

        // constant zero never locks
        do_reset();
        for (int k = 0; k < 2000; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("zero_locked0", locked0, 0);
        chk("zero_locked1", locked1, 0);
        chk("zero_bits",    bc0, 0);
        chk("zero_errs",    ec0, 0);
        chk("zero_relock",  rc0, 0);
        clean(150);
        settle();
        chk("zero_then_lock0", locked0, 1);
        chk("zero_then_lock1", locked1, 1);

        // gapped valid: lock after 48 valid bits
        do_reset();
        vcount = 0;
        for (int it = 0; it < 2000 && vcount < 48; it++) begin
            v = 1'($urandom);
            cyc(v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (v) begin
                vcount++;
                if (vcount >= 47) begin
                    settle();
                    chk("gap_lock_at_48", locked0, (vcount == 48) ? 1 : 0);
                end
            end
        end
        chk("gap_valid_count", vcount, 48);

        // random gaps, errors and clears
        for (int it = 0; it < 3000; it++) begin
            cyc(1'($urandom), ($urandom % 64) == 0, ($urandom % 8) == 0,
                ($urandom % 128) == 0, 1'b0, 1'b0);
        end

        // reset while locked
        do_reset();
        clean(60);
        settle();
        chk("pre_rst_locked", locked0, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("midrst_locked", locked0, 0);
        chk("midrst_pulse",  pulse0,  0);
        chk("midrst_bits",   bc0,     0);
        chk("midrst_errs",   ec0,     0);
        chk("midrst_relock", rc0,     0);
        lock_after_48("midrst_relock_at_48");

        // clear on the same cycle as an errored bit
        clean(5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("pre_clear_errs", ec0, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("clear_errs",  ec0, 0);
        chk("clear_pulse", pulse0, 1);
        chk("clear_bits",  bc0, 0);
        clean(3);
        settle();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs16_checker.md
Name: prbs16_checker

Overview:
- Receive-side counterpart of the team's 16-bit LFSR random source. Takes the generator's serial output bit (the new LSB shifted in each step) and self-synchronizes a local LFSR to it.
- Once synchronized, it flags and counts bit errors.
- Used on the receive side of link simulations to measure BER and to detect loss of sync.

Parameters:
- POLY_SEL, 0, tap set. 0: feedback = s[15]^s[13]^s[12]^s[10]. 1: feedback = s[15]^s[14]^s[12]^s[3]. Must match the transmitter; the transmitter uses odd seed → 0, even seed → 1.
- LOCK_CNT, 32, consecutive correct predictions required to declare lock (1..255).
- WIN_LEN, 256, bits per error-monitoring window while locked (2..65535).
- ERR_THRESH, 8, errors within one window that force loss of lock (1..WIN_LEN).
- CNT_W, 32, width of the bit and error counters.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous reset, active-high.
- bit_i, input, 1, received serial bit.
- valid_i, input, 1, bit_i is valid this cycle. No state change when low.
- clear_i, input, 1, synchronously zeroes the statistics counters. Lock state is unaffected.
- locked_o, output, 1, checker is in LOCKED.
- err_pulse_o, output, 1, one-cycle pulse per errored bit while locked.
- bit_cnt_o, output, CNT_W, valid bits checked while locked.
- err_cnt_o, output, CNT_W, errored bits while locked.
- relock_cnt_o, output, 8, number of LOCKED→FILL transitions.

Behaviour:
- Clock and reset: single clock domain; all outputs registered.
- Reset: rst=1 at a clk edge → state=FILL; sreg, fill_cnt, match_cnt, win_cnt, win_err = 0. All outputs 0. Reset mid-operation behaves identically; no partial state survives.
- Nothing advances on cycles with valid_i=0; err_pulse_o is 0 on those cycles.
- Prediction: pred = feedback(sreg) per POLY_SEL. Shift operation is sreg <= {sreg[14:0], b}.
- FILL state:
  - Each valid bit: shift in bit_i; fill_cnt increments, saturating at 16.
  - When fill_cnt reaches 16 and the post-shift sreg is nonzero → VERIFY, match_cnt=0.
  - All-zero sreg: remain in FILL and keep shifting (lock-up state is never accepted).
- VERIFY state:
  - Each valid bit: shift in bit_i (received, not predicted).
  - bit_i==pred: match_cnt++. When match_cnt reaches LOCK_CNT → LOCKED; win_cnt=0, win_err=0.
  - bit_i!=pred: → FILL with fill_cnt=0.
- LOCKED state:
  - Each valid bit: shift in pred, not bit_i, so a single error does not propagate. bit_cnt++.
  - On mismatch: err_cnt++, err_pulse_o=1 on the next cycle (latency 1), win_err++.
  - win_cnt++. When win_cnt reaches WIN_LEN, win_cnt=0 and win_err=0.
  - If win_err reaches ERR_THRESH (counting the current bit): → FILL with fill_cnt=0, relock_cnt++, locked_o falls the next cycle.
  - The bit that triggers loss of lock is still counted in bit_cnt and err_cnt.
- locked_o timing: rises the cycle after the LOCK_CNT-th consecutive match. With continuous valid bits from a clean stream, that is the cycle after valid bit 16+LOCK_CNT (48 at defaults).
- Counters: all saturate at their maximum and never wrap.
- clear_i: clears bit_cnt, err_cnt and relock_cnt. Clear has priority over a same-cycle increment, so the result is 0 and that event is dropped. err_pulse_o is still generated.
- Widths: win_cnt and win_err are 16 bits; match_cnt is 8 bits; fill_cnt is 5 bits.

Test Plan:
- Clean stream (transmitter POLY_SEL=0, seed 16'h0005, valid_i=1, 1000 bits): locked_o=1 from the cycle after bit 48. After 1000 bits: bit_cnt_o=952, err_cnt_o=0, relock_cnt_o=0, no err_pulse_o.
- Single bit inversion at locked bit 200: exactly one err_pulse_o, 1 cycle after that bit. err_cnt_o=1, locked_o stays 1, zero further errors over the next 500 bits.
- Burst inversion of 8 consecutive bits while locked (defaults): locked_o drops after the 8th error, err_cnt_o=8, relock_cnt_o=1. Clean bits resume → locked_o=1 again after 48 further bits.
- Constant bit_i=0 for 2000 cycles: stays in FILL, locked_o=0, all counters 0. Same test with POLY_SEL=1 and a seed-even transmitter must lock normally.
- Clean stream with valid_i toggled pseudo-randomly (~50%): counts equal the valid-only count. Lock occurs after 48 valid bits regardless of gaps.
- Reset and clear:
  - rst=1 for one cycle while locked: next cycle all outputs are 0; relock after 48 bits.
  - clear_i asserted on the same cycle as an errored bit: err_cnt_o=0, err_pulse_o=1.
